// File: rtl/nn_req_scheduler_pkg.sv
// ============================================================================
// Module : nn_sched_pkg
// Brief  : Shared state encoding, default timeout and index decode helper for
//          the perceptron request scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_sched_pkg;

    localparam int c_default_timeout = 1024;
    localparam int c_max_nreq        = 8;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_ISSUE = c_st_issue,
        ST_WAIT  = c_st_wait,
        ST_RESP  = c_st_resp
    } state_t;

    // Decodes an index into a one-hot vector sized for the largest requester count.
    function automatic logic [c_max_nreq-1:0] onehot_idx(input logic [2:0] idx);
        return {{(c_max_nreq-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nn_req_scheduler_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick; searches from last_grant+1 with wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid
);

    always_comb begin
        int k;
        k         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Offset 1 first so the previous winner is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            k = int'(last_grant) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!gnt_valid && req[IW'(k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nn_req_scheduler.sv
// ============================================================================
// Module : nn_req_scheduler
// Brief  : Round-robin sharing of one perceptron4 among NREQ requesters, with
//          start pulse, done wait with timeout, and per-request ack/status.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_req_scheduler
    import nn_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = c_default_timeout,
    parameter int TOW     = $clog2(TIMEOUT),
    parameter int ERRW    = 8
) (
    input  logic            CLK100MHZ,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic            rsp_out,
    output logic            rsp_err,
    output logic            busy,
    output logic            nn_start,
    input  logic            nn_done,
    input  logic            nn_out,
    output logic [ERRW-1:0] err_cnt
);

    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_last_grant;
    logic [TOW-1:0]  r_tcnt;
    logic [NREQ-1:0] r_ack;
    logic            r_rsp_out;
    logic            r_rsp_err;
    logic            r_busy;
    logic            r_nn_start;
    logic [ERRW-1:0] r_err_cnt;

    logic [IW-1:0]   w_gnt_idx;
    logic            w_gnt_valid;
    logic            w_done_hit;
    logic            w_tmo_hit;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req        (req),
        .last_grant (r_last_grant),
        .gnt_idx    (w_gnt_idx),
        .gnt_valid  (w_gnt_valid)
    );

    always_comb begin
        w_state_next = r_state;
        w_done_hit   = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_gnt_valid) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT: begin
                // Done takes precedence over a timeout in the same cycle.
                if (nn_done) begin
                    w_done_hit   = 1'b1;
                    w_state_next = ST_RESP;
                end else if (r_tcnt == TOW'(TIMEOUT - 1)) begin
                    w_tmo_hit    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_last_grant <= IW'(NREQ - 1);
            r_tcnt       <= '0;
            r_ack        <= '0;
            r_rsp_out    <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_nn_start   <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= (w_state_next != ST_IDLE);
            r_nn_start <= (w_state_next == ST_ISSUE);
            r_ack      <= (w_state_next == ST_RESP) ? NREQ'(onehot_idx(3'(r_idx))) : '0;

            if (r_state == ST_IDLE && w_gnt_valid) r_idx <= w_gnt_idx;
            if (r_state == ST_RESP) r_last_grant <= r_idx;

            if (r_state == ST_ISSUE) begin
                r_tcnt <= '0;
            end else if (r_state == ST_WAIT && !w_done_hit && !w_tmo_hit) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_done_hit) begin
                r_rsp_out <= nn_out;
                r_rsp_err <= 1'b0;
            end else if (w_tmo_hit) begin
                r_rsp_out <= 1'b0;
                r_rsp_err <= 1'b1;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign ack      = r_ack;
    assign rsp_out  = r_rsp_out;
    assign rsp_err  = r_rsp_err;
    assign busy     = r_busy;
    assign nn_start = r_nn_start;
    assign err_cnt  = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nn_req_scheduler.sv
// ============================================================================
// Module : tb_nn_req_scheduler
// Brief  : Directed self-checking bench for nn_req_scheduler (NREQ=4, TIMEOUT=16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nn_req_scheduler;

    logic       CLK100MHZ;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic       rsp_out;
    logic       rsp_err;
    logic       busy;
    logic       nn_start;
    logic       nn_done;
    logic       nn_out;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    nn_req_scheduler #(.NREQ(4), .TIMEOUT(16), .ERRW(8)) dut (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .rsp_out   (rsp_out),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .nn_start  (nn_start),
        .nn_done   (nn_done),
        .nn_out    (nn_out),
        .err_cnt   (err_cnt)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    // Advance one clock; outputs are stable and inputs may be changed afterwards.
    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0; nn_done = 1'b0; nn_out = 1'b0;
        step(); step();
        rst = 1'b0;
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (nn_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", nn_start); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
        n_cmp++; if ({rsp_out, rsp_err} !== 2'b00) begin n_err++; $display("FAIL reset_rsp: got %b want 00", {rsp_out, rsp_err}); end
    endtask

    task automatic test_single();
        req = 4'b0010;
        step();
        n_cmp++; if (nn_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", nn_start); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        repeat (5) step();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL single_early_ack: got %b want 0000", ack); end
        nn_done = 1'b1; nn_out = 1'b1;
        step();
        n_cmp++; if (ack !== 4'b0010) begin n_err++; $display("FAIL single_ack: got %b want 0010", ack); end
        n_cmp++; if (rsp_out !== 1'b1) begin n_err++; $display("FAIL single_rsp_out: got %b want 1", rsp_out); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL single_rsp_err: got %b want 0", rsp_err); end
        nn_done = 1'b0; req = 4'b0000;
        step();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_once: got %b want 0000", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", busy); end
        step();
        n_cmp++; if (nn_start !== 1'b0) begin n_err++; $display("FAIL single_no_restart: got %b want 0", nn_start); end
    endtask

    task automatic test_round_robin();
        logic [3:0] seen [5];
        int         cyc  [5];
        logic [3:0] exp_ack [5];
        int         got;
        int         bad_out;
        exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100;
        exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
        got = 0; bad_out = 0;
        for (int k = 0; k < 5; k++) begin seen[k] = 4'b0; cyc[k] = 0; end
        pulse_reset();
        req = 4'b1111; nn_done = 1'b1; nn_out = 1'b0;
        for (int i = 0; i < 40 && got < 5; i++) begin
            step();
            if (ack !== 4'b0000) begin
                seen[got] = ack;
                cyc[got]  = i;
                if (rsp_out !== 1'b0) bad_out++;
                got++;
                if (got == 5) req = 4'b0000;
            end
        end
        nn_done = 1'b0;
        n_cmp++; if (got !== 5) begin n_err++; $display("FAIL rr_count: got %0d acks want 5", got); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (seen[k] !== exp_ack[k]) begin n_err++; $display("FAIL rr_ack%0d: got %b want %b", k, seen[k], exp_ack[k]); end
        end
        for (int k = 1; k < 5; k++) begin
            n_cmp++; if (cyc[k] - cyc[k-1] !== 4) begin n_err++; $display("FAIL rr_turnaround%0d: got %0d want 4", k, cyc[k] - cyc[k-1]); end
        end
        n_cmp++; if (bad_out !== 0) begin n_err++; $display("FAIL rr_rsp_out: got %0d nonzero want 0", bad_out); end
        step();
    endtask

    task automatic test_timeout();
        pulse_reset();
        req = 4'b0100; nn_done = 1'b0; nn_out = 1'b1;
        step();
        n_cmp++; if (nn_start !== 1'b1) begin n_err++; $display("FAIL tmo_start: got %b want 1", nn_start); end
        step();
        repeat (15) step();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL tmo_early_ack: got %b want 0000", ack); end
        step();
        n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL tmo_ack: got %b want 0100", ack); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL tmo_rsp_err: got %b want 1", rsp_err); end
        n_cmp++; if (rsp_out !== 1'b0) begin n_err++; $display("FAIL tmo_rsp_out: got %b want 0", rsp_out); end
        n_cmp++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL tmo_errcnt: got %0d want 1", err_cnt); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_err_saturate();
        int nacks;
        int bad_err;
        logic [7:0] mid_cnt;
        nacks = 0; bad_err = 0; mid_cnt = 8'd0;
        req = 4'b0001; nn_done = 1'b0;
        for (int i = 0; i < 7000 && nacks < 299; i++) begin
            step();
            if (ack !== 4'b0000) begin
                nacks++;
                if (rsp_err !== 1'b1) bad_err++;
                if (nacks == 100) mid_cnt = err_cnt;
                if (nacks == 299) req = 4'b0000;
            end
        end
        n_cmp++; if (nacks !== 299) begin n_err++; $display("FAIL sat_count: got %0d acks want 299", nacks); end
        n_cmp++; if (mid_cnt !== 8'd101) begin n_err++; $display("FAIL sat_mid: got %0d want 101", mid_cnt); end
        n_cmp++; if (err_cnt !== 8'd255) begin n_err++; $display("FAIL sat_errcnt: got %0d want 255", err_cnt); end
        n_cmp++; if (bad_err !== 0) begin n_err++; $display("FAIL sat_rsp_err: got %0d bad want 0", bad_err); end
        step();
    endtask

    task automatic test_tie();
        pulse_reset();
        req = 4'b1000; nn_done = 1'b0;
        step(); step();
        repeat (15) step();
        nn_done = 1'b1; nn_out = 1'b1;
        step();
        n_cmp++; if (ack !== 4'b1000) begin n_err++; $display("FAIL tie_ack: got %b want 1000", ack); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL tie_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (rsp_out !== 1'b1) begin n_err++; $display("FAIL tie_rsp_out: got %b want 1", rsp_out); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL tie_errcnt: got %0d want 0", err_cnt); end
        nn_done = 1'b0; req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] seen [2];
        int         got;
        got = 0; seen[0] = 4'b0; seen[1] = 4'b0;
        req = 4'b0010; nn_done = 1'b0;
        repeat (18) step();
        n_cmp++; if ({ack, err_cnt} !== {4'b0010, 8'd1}) begin n_err++; $display("FAIL rmw_pre: got ack %b cnt %0d want 0010 1", ack, err_cnt); end
        req = 4'b1001;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_busy: got %b want 0", busy); end
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rmw_ack: got %b want 0000", ack); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL rmw_errcnt: got %0d want 0", err_cnt); end
        nn_done = 1'b1;
        for (int i = 0; i < 20 && got < 2; i++) begin
            step();
            if (ack !== 4'b0000) begin
                seen[got] = ack;
                got++;
                if (got == 2) req = 4'b0000;
            end
        end
        nn_done = 1'b0;
        n_cmp++; if (seen[0] !== 4'b0001) begin n_err++; $display("FAIL rmw_first: got %b want 0001", seen[0]); end
        n_cmp++; if (seen[1] !== 4'b1000) begin n_err++; $display("FAIL rmw_second: got %b want 1000", seen[1]); end
        step();
    endtask

    task automatic test_stray_done();
        int n_st;
        int n_ack;
        logic [3:0] last_ack;
        n_st = 0; n_ack = 0; last_ack = 4'b0;
        nn_done = 1'b1; nn_out = 1'b1;
        step();
        nn_done = 1'b0;
        step();
        n_cmp++; if ({busy, nn_start, ack} !== 6'b0) begin n_err++; $display("FAIL stray_idle: got %b want 000000", {busy, nn_start, ack}); end
        req = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            step();
            if (nn_start === 1'b1) n_st++;
            if (ack !== 4'b0000) begin n_ack++; last_ack = ack; req = 4'b0000; end
            nn_done = busy & ~nn_start;
        end
        nn_done = 1'b0;
        n_cmp++; if (n_st !== 1) begin n_err++; $display("FAIL stray_starts: got %0d want 1", n_st); end
        n_cmp++; if (n_ack !== 1) begin n_err++; $display("FAIL stray_acks: got %0d want 1", n_ack); end
        n_cmp++; if (last_ack !== 4'b0001) begin n_err++; $display("FAIL stray_ack_val: got %b want 0001", last_ack); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_err_saturate();
        test_tie();
        test_reset_mid_wait();
        test_stray_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
